// File: rtl/dds_pkg.sv
// Shared types, latency constants and quarter-wave table generator for the DDS NCO.
// Build option DDS_INTERP_EN selects linear interpolation (latency 5) instead of truncated lookup (latency 3).
package dds_pkg;

  localparam int LAT_TRUNC  = 3;
  localparam int LAT_INTERP = 5;
`ifdef DDS_INTERP_EN
  localparam int LAT = LAT_INTERP;
`else
  localparam int LAT = LAT_TRUNC;
`endif

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  localparam real PI = 3.14159265358979323846;

  // Half-sample offset keeps the quarter-wave mirror exact and the peak below full scale.
  function automatic int sine_entry(input int k, input int lut_aw, input int out_w);
    real amp;
    real ang;
    int  q;
    q   = 32'sd1 <<< (lut_aw - 2);
    amp = real'((64'sd1 <<< (out_w - 1)) - 64'sd1);
    ang = PI / 2.0 * (real'(k) + 0.5) / real'(q);
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/sine_fold_rom.sv
// Quadrant fold, quarter-wave ROM register and sign/output register for one full-wave read port.
module sine_fold_rom
  import dds_pkg::*;
#(
  parameter int LUT_AW = 9,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rom_ld_i,
  input  logic                    out_ld_i,
  input  logic [LUT_AW-1:0]       addr_i,
  output logic signed [OUT_W-1:0] val_o
);

  localparam int Q = 2 ** (LUT_AW - 2);

  logic [OUT_W-1:0] rom_s [Q];

  for (genvar k = 0; k < Q; k++) begin : g_rom
    assign rom_s[k] = OUT_W'(sine_entry(k, LUT_AW, OUT_W));
  end

  quad_e                   quad_s;
  logic [LUT_AW-3:0]       idx_s;
  logic                    neg_s;
  logic [OUT_W-1:0]        mag_q, mag_d;
  logic                    neg_q, neg_d;
  logic signed [OUT_W-1:0] val_q, val_d;

  always_comb begin
    quad_s = quad_e'(addr_i[LUT_AW-1 -: 2]);
    idx_s  = addr_i[LUT_AW-3:0];
    neg_s  = 1'b0;
    case (quad_s)
      QUAD_0:  begin idx_s = addr_i[LUT_AW-3:0];  neg_s = 1'b0; end
      QUAD_1:  begin idx_s = ~addr_i[LUT_AW-3:0]; neg_s = 1'b0; end
      QUAD_2:  begin idx_s = addr_i[LUT_AW-3:0];  neg_s = 1'b1; end
      QUAD_3:  begin idx_s = ~addr_i[LUT_AW-3:0]; neg_s = 1'b1; end
      default: begin idx_s = addr_i[LUT_AW-3:0];  neg_s = 1'b0; end
    endcase
  end

  always_comb begin
    mag_d = mag_q;
    neg_d = neg_q;
    val_d = val_q;
    if (rom_ld_i) begin
      mag_d = rom_s[idx_s];
      neg_d = neg_s;
    end else begin
      mag_d = mag_q;
      neg_d = neg_q;
    end
    if (out_ld_i) begin
      val_d = neg_q ? -$signed(mag_q) : $signed(mag_q);
    end else begin
      val_d = val_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q <= '0;
      neg_q <= 1'b0;
      val_q <= '0;
    end else begin
      mag_q <= mag_d;
      neg_q <= neg_d;
      val_q <= val_d;
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/dds_nco.sv
// Quadrature DDS numerically controlled oscillator: phase accumulator, offset and sin/cos lookup.
// Define DDS_INTERP_EN for linear interpolation between table points (adds multiply and add stages).
module dds_nco
  import dds_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 9,
  parameter int OUT_W   = 16,
  parameter int FRAC_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [PHASE_W-1:0]      phase_inc,
  input  logic                    inc_load,
  input  logic [PHASE_W-1:0]      phase_off,
  input  logic                    sync_clr,
  output logic signed [OUT_W-1:0] sin_o,
  output logic signed [OUT_W-1:0] cos_o,
  output logic                    valid_o
);

  localparam logic [LUT_AW-1:0] QOFF = LUT_AW'(2 ** (LUT_AW - 2));

  logic [PHASE_W-1:0] acc_q, acc_d, inc_q, inc_d, used_s, samp_s;
  logic [LUT_AW-1:0]  sa_q, sa_d;
  logic [LAT-1:0]     vld_q, vld_d;
  logic               unused_samp_s;

  always_comb begin
    used_s = sync_clr ? {PHASE_W{1'b0}} : acc_q;
    samp_s = used_s + phase_off;
    vld_d  = {vld_q[LAT-2:0], en};
    if (en) begin
      acc_d = used_s + inc_q;
      sa_d  = samp_s[PHASE_W-1 -: LUT_AW];
    end else begin
      acc_d = used_s;
      sa_d  = sa_q;
    end
    if (inc_load) begin
      inc_d = phase_inc;
    end else begin
      inc_d = inc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      inc_q <= '0;
      sa_q  <= '0;
      vld_q <= '0;
    end else begin
      acc_q <= acc_d;
      inc_q <= inc_d;
      sa_q  <= sa_d;
      vld_q <= vld_d;
    end
  end

  assign unused_samp_s = ^samp_s;
  assign valid_o       = vld_q[LAT-1];

  logic signed [OUT_W-1:0] s0_s, c0_s;

  sine_fold_rom #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_sin0 (
    .clk(clk), .rst(rst), .rom_ld_i(vld_q[0]), .out_ld_i(vld_q[1]),
    .addr_i(sa_q), .val_o(s0_s)
  );
  sine_fold_rom #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_cos0 (
    .clk(clk), .rst(rst), .rom_ld_i(vld_q[0]), .out_ld_i(vld_q[1]),
    .addr_i(sa_q + QOFF), .val_o(c0_s)
  );

`ifdef DDS_INTERP_EN
  localparam int PW = OUT_W + FRAC_W + 2;

  logic signed [OUT_W-1:0] s1_s, c1_s;
  logic [FRAC_W-1:0]       f1_q, f1_d, f2_q, f2_d, f3_q, f3_d;
  logic signed [OUT_W:0]   dsin_s, dcos_s;
  logic signed [PW-1:0]    ps_q, ps_d, pc_q, pc_d;
  logic signed [OUT_W-1:0] bs_q, bs_d, bc_q, bc_d, so_q, so_d, co_q, co_d;

  sine_fold_rom #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_sin1 (
    .clk(clk), .rst(rst), .rom_ld_i(vld_q[0]), .out_ld_i(vld_q[1]),
    .addr_i(sa_q + LUT_AW'(1)), .val_o(s1_s)
  );
  sine_fold_rom #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_cos1 (
    .clk(clk), .rst(rst), .rom_ld_i(vld_q[0]), .out_ld_i(vld_q[1]),
    .addr_i(sa_q + QOFF + LUT_AW'(1)), .val_o(c1_s)
  );

  // Fraction rides alongside the table pipeline; product and sum keep full precision.
  always_comb begin
    f1_d   = en       ? samp_s[PHASE_W-LUT_AW-1 -: FRAC_W] : f1_q;
    f2_d   = vld_q[0] ? f1_q : f2_q;
    f3_d   = vld_q[1] ? f2_q : f3_q;
    dsin_s = {s1_s[OUT_W-1], s1_s} - {s0_s[OUT_W-1], s0_s};
    dcos_s = {c1_s[OUT_W-1], c1_s} - {c0_s[OUT_W-1], c0_s};
    if (vld_q[2]) begin
      ps_d = PW'(dsin_s) * PW'($signed({1'b0, f3_q}));
      pc_d = PW'(dcos_s) * PW'($signed({1'b0, f3_q}));
      bs_d = s0_s;
      bc_d = c0_s;
    end else begin
      ps_d = ps_q;
      pc_d = pc_q;
      bs_d = bs_q;
      bc_d = bc_q;
    end
    if (vld_q[3]) begin
      so_d = OUT_W'(PW'(bs_q) + (ps_q >>> FRAC_W));
      co_d = OUT_W'(PW'(bc_q) + (pc_q >>> FRAC_W));
    end else begin
      so_d = so_q;
      co_d = co_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f1_q <= '0; f2_q <= '0; f3_q <= '0;
      ps_q <= '0; pc_q <= '0; bs_q <= '0; bc_q <= '0;
      so_q <= '0; co_q <= '0;
    end else begin
      f1_q <= f1_d; f2_q <= f2_d; f3_q <= f3_d;
      ps_q <= ps_d; pc_q <= pc_d; bs_q <= bs_d; bc_q <= bc_d;
      so_q <= so_d; co_q <= co_d;
    end
  end

  assign sin_o = so_q;
  assign cos_o = co_q;
`else
  logic [FRAC_W-1:0] unused_frac_s;
  assign unused_frac_s = samp_s[PHASE_W-LUT_AW-1 -: FRAC_W];
  assign sin_o = s0_s;
  assign cos_o = c0_s;
`endif

endmodule

// File: tb/tb_dds_nco.sv
// Self-checking bench for dds_nco: table vectors, directed corner sequences and a random scoreboard run.
module tb_dds_nco;

`ifdef DDS_INTERP_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic               clk = 1'b0;
  logic               rst, en, inc_load, sync_clr;
  logic [31:0]        phase_inc, phase_off;
  logic signed [15:0] sin_o, cos_o;
  logic               valid_o;

  dds_nco #(.PHASE_W(32), .LUT_AW(9), .OUT_W(16), .FRAC_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .phase_inc(phase_inc), .inc_load(inc_load),
    .phase_off(phase_off), .sync_clr(sync_clr), .sin_o(sin_o), .cos_o(cos_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {int due; int s; int c;} samp_t;
  typedef struct {logic [31:0] off; int s; int c;} vec_t;

  samp_t       exp_q[$];
  int          obs_s[$], obs_c[$];
  logic [31:0] m_acc, m_inc;
  int          held_s, held_c, cyc, n_chk, n_fail;
  vec_t        vt[7];

  // Ideal full-wave sample at bin n (centre of bin), rounded half away from zero.
  function automatic int rv(int n);
    real x;
    x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * (real'(n % 512) + 0.5) / 512.0);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(0.5 - x);
  endfunction

  function automatic int ref_val(logic [31:0] ph);
    int n;
    n = int'(ph[31:23]);
`ifdef DDS_INTERP_EN
    begin
      int e0, e1, f;
      e0 = rv(n);
      e1 = rv((n + 1) % 512);
      f  = int'(ph[22:15]);
      return e0 + (((e1 - e0) * f) >>> 8);
    end
`else
    return rv(n);
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic model_edge();
    logic [31:0] pu, sp;
    samp_t e;
    if (rst) begin
      m_acc = 32'd0; m_inc = 32'd0;
      exp_q.delete();
      held_s = 0; held_c = 0;
    end else begin
      pu = sync_clr ? 32'd0 : m_acc;
      if (en) begin
        sp = pu + phase_off;
        e.due = cyc + LAT; e.s = ref_val(sp); e.c = ref_val(sp + 32'h4000_0000);
        exp_q.push_back(e);
        m_acc = pu + m_inc;
      end else begin
        m_acc = pu;
      end
      if (inc_load) m_inc = phase_inc;
    end
  endtask

  task automatic check_cycle();
    if (valid_o === 1'b1) begin
      obs_s.push_back(int'(sin_o));
      obs_c.push_back(int'(cos_o));
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      chk("sb_valid", int'(valid_o), 1);
      chk("sb_sin", int'(sin_o), exp_q[0].s);
      chk("sb_cos", int'(cos_o), exp_q[0].c);
      held_s = exp_q[0].s;
      held_c = exp_q[0].c;
      void'(exp_q.pop_front());
    end else begin
      chk("sb_idle_valid", int'(valid_o), 0);
      chk("sb_hold_sin", int'(sin_o), held_s);
      chk("sb_hold_cos", int'(cos_o), held_c);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic idle(input int n);
    en = 1'b0; sync_clr = 1'b0; inc_load = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_inc(input logic [31:0] v);
    phase_inc = v; inc_load = 1'b1; en = 1'b0;
    step();
    inc_load = 1'b0;
  endtask

  initial begin
    int k, got, gs, gc;
    logic [31:0] ph;
    n_chk = 0; n_fail = 0; cyc = 0; held_s = 0; held_c = 0;
    m_acc = 32'd0; m_inc = 32'd0;
    rst = 1'b1; en = 1'b0; inc_load = 1'b0; sync_clr = 1'b0;
    phase_inc = 32'd0; phase_off = 32'd0;

    vt[0] = '{32'h0000_0000,    201,  32766};
    vt[1] = '{32'h4000_0000,  32766,   -201};
    vt[2] = '{32'h8000_0000,   -201, -32766};
    vt[3] = '{32'hC000_0000, -32766,    201};
    vt[4] = '{32'h0080_0000,    603,  32761};
`ifdef DDS_INTERP_EN
    vt[5] = '{32'h007F_FFFF,    601,  32761};
    vt[6] = '{32'hFFFF_FFFF,    199,  32766};
`else
    vt[5] = '{32'h007F_FFFF,    201,  32766};
    vt[6] = '{32'hFFFF_FFFF,   -201,  32766};
`endif

    // Reset state
    step(); step();
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_sin", int'(sin_o), 0);
    chk("rst_cos", int'(cos_o), 0);
    rst = 1'b0;

    // Basic tone, inc 2^23: latency, first sample and quarter-period sample
    load_inc(32'h0080_0000);
    obs_s.delete(); obs_c.delete();
    en = 1'b1;
    k = 0;
    for (int i = 0; i < 10 && valid_o !== 1'b1; i++) begin step(); k++; end
    chk("first_latency", k, LAT);
    for (int i = 0; i < 200 && obs_s.size() < 129; i++) step();
    chk("tone_count", int'(obs_s.size() >= 129), 1);
    if (obs_s.size() >= 129) begin
      chk("tone_s0_sin", obs_s[0], 201);
      chk("tone_s0_cos", obs_c[0], 32766);
      chk("tone_s128_sin", obs_s[128], 32766);
      chk("tone_s128_cos", obs_c[128], -201);
    end
    idle(LAT + 1);

    // Nyquist tone: inc 2^31 alternates and wraps
    load_inc(32'h8000_0000);
    obs_s.delete(); obs_c.delete();
    en = 1'b1; sync_clr = 1'b1; step(); sync_clr = 1'b0;
    for (int i = 0; i < 7; i++) step();
    idle(LAT + 1);
    chk("nyq_count", obs_s.size(), 8);
    for (int i = 0; i < 8 && i < obs_s.size(); i++)
      chk("nyq_sin", obs_s[i], (i % 2 == 0) ? 201 : -201);

    // Resync with en mid-stream
    load_inc(32'h0080_0000);
    obs_s.delete(); obs_c.delete();
    en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    sync_clr = 1'b1; step(); sync_clr = 1'b0; step();
    idle(LAT + 1);
    chk("sync_count", obs_s.size(), 7);
    if (obs_s.size() >= 7) begin
      chk("sync_sin_a", obs_s[5], 201);
      chk("sync_sin_b", obs_s[6], 603);
    end

    // Increment reload with en: old step used for that advance, doubled afterwards
    obs_s.delete(); obs_c.delete();
    en = 1'b1; sync_clr = 1'b1; step(); sync_clr = 1'b0;
    step(); step();
    phase_inc = 32'h0100_0000; inc_load = 1'b1; step(); inc_load = 1'b0;
    step(); step(); step();
    idle(LAT + 1);
    chk("reload_count", obs_s.size(), 7);
    for (int i = 0; i < 7 && i < obs_s.size(); i++) begin
      ph = (i <= 4) ? (32'(i) << 23) : (32'(2 * i - 4) << 23);
      chk("reload_sin", obs_s[i], ref_val(ph));
      chk("reload_cos", obs_c[i], ref_val(ph + 32'h4000_0000));
    end

    // Gapped enable: 1-0-1
    obs_s.delete(); obs_c.delete();
    en = 1'b1; step(); en = 1'b0; step(); en = 1'b1; step();
    idle(LAT + 3);
    chk("gap_pulses", obs_s.size(), 2);

    // Reset mid-stream discards in-flight samples
    en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1; step();
    chk("mrst_valid", int'(valid_o), 0);
    chk("mrst_sin", int'(sin_o), 0);
    chk("mrst_cos", int'(cos_o), 0);
    rst = 1'b0; obs_s.delete(); obs_c.delete();
    idle(LAT + 5);
    chk("mrst_no_valid", obs_s.size(), 0);
    load_inc(32'h0040_0000);
    en = 1'b1; step(); step();
    idle(LAT + 1);
    chk("mrst_count", obs_s.size(), 2);
`ifdef DDS_INTERP_EN
    if (obs_s.size() >= 2) chk("mrst_second_sin", obs_s[1], 402);
`else
    if (obs_s.size() >= 2) chk("mrst_second_sin", obs_s[1], 201);
`endif

    // Table of single-sample phase vectors
    for (int v = 0; v < 7; v++) begin
      phase_off = vt[v].off; sync_clr = 1'b1; en = 1'b1;
      step();
      sync_clr = 1'b0; en = 1'b0;
      got = 0; gs = 0; gc = 0;
      for (int w = 0; w < LAT + 2 && got == 0; w++) begin
        step();
        if (valid_o === 1'b1) begin got = 1; gs = int'(sin_o); gc = int'(cos_o); end
      end
      chk("tbl_seen", got, 1);
      if (got == 1) begin
        chk("tbl_sin", gs, vt[v].s);
        chk("tbl_cos", gc, vt[v].c);
      end
    end
    phase_off = 32'd0;
    idle(2);

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      sync_clr  = ($urandom_range(0, 31) == 0);
      inc_load  = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      phase_inc = $urandom;
      phase_off = $urandom;
      step();
    end
    rst = 1'b0;
    idle(LAT + 2);
    chk("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_nco.md
DDS_NCO -- requirements
Module: dds_nco

Interface
REQ-001 SHALL have parameter PHASE_W, default 32: phase accumulator width.
REQ-002 SHALL have parameter LUT_AW, default 9: full-wave address bits; minimum 4.
REQ-003 SHALL have parameter OUT_W, default 16: signed output width.
REQ-004 SHALL have parameter FRAC_W, default 8: interpolation fraction bits; PHASE_W >= LUT_AW+FRAC_W.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port en, input, 1: produce one sample this cycle and advance phase.
REQ-008 SHALL have port phase_inc, input, PHASE_W: frequency tuning word, captured on inc_load.
REQ-009 SHALL have port inc_load, input, 1: load phase_inc into the internal increment register.
REQ-010 SHALL have port phase_off, input, PHASE_W: phase offset, unregistered and sampled with en.
REQ-011 SHALL have port sync_clr, input, 1: clear the accumulator (phase resync).
REQ-012 SHALL have port sin_o, output, OUT_W signed: sine sample.
REQ-013 SHALL have port cos_o, output, OUT_W signed: cosine sample.
REQ-014 SHALL have port valid_o, output, 1: sin_o/cos_o hold a new sample.

Function
REQ-015 SHALL compute phase_used = sync_clr ? 0 : acc, and acc_next = en ? phase_used+inc_reg : phase_used, with wrap modulo 2^PHASE_W.
REQ-016 SHALL compute sample phase as phase_used+phase_off mod 2^PHASE_W; cosine phase SHALL be that value plus 2^(PHASE_W-2).
REQ-017 SHALL use the top LUT_AW phase bits as table address and truncate the remaining bits, with no dither.
REQ-018 SHALL, on inc_load, apply the new inc_reg from the next cycle; inc_load with en in the same cycle SHALL advance by the old increment.
REQ-019 SHALL hold a quarter table of Q=2^(LUT_AW-2) entries, entry k = round((2^(OUT_W-1)-1)*sin(pi/2*(k+0.5)/Q)), half-sample offset so the mirror is exact.
REQ-020 SHALL fold by quadrant = addr[MSB:MSB-1]: Q0 direct; Q1 mirror (Q-1-a); Q2 direct, negated; Q3 mirror, negated.
REQ-021 SHALL never produce -2^(OUT_W-1), so negation never overflows.
REQ-022 SHALL pipeline the datapath as phase add/fold register -> ROM register -> sign/output register, giving latency LAT=3 from en to valid_o.
REQ-023 SHALL assert valid_o exactly LAT cycles after each cycle with en=1, for one cycle per sample.
REQ-024 SHALL hold sin_o/cos_o when valid_o=0.
REQ-025 SHALL accept back-to-back en with throughput of one sample per cycle.

Reset
REQ-026 SHALL, while rst=1, clear acc, inc_reg, all pipeline registers, sin_o, cos_o and valid_o to 0 at the next edge.
REQ-027 SHALL give rst priority over en, sync_clr and inc_load.
REQ-028 SHALL, on rst mid-stream, discard all in-flight samples with no valid_o afterwards.

Configuration
REQ-029 SHALL, with DDS_INTERP_EN defined, output e(a) + (((e(a+1)-e(a)) * f) >>> FRAC_W), where e is the folded full-wave value, f is the next FRAC_W phase bits, and a+1 wraps mod 2^LUT_AW.
REQ-030 SHALL, with DDS_INTERP_EN defined, use arithmetic shift and full-precision intermediates, and set LAT=5 (multiply stage plus add stage).
REQ-031 SHALL, without DDS_INTERP_EN, use truncated lookup only, LAT=3, and no multipliers.

Structure
REQ-032 SHALL place the LAT constants, the quadrant enum and the table-generation function in package dds_pkg.
REQ-033 SHALL implement fold+ROM+negate as sub-module sine_fold_rom (full address in, registered signed value out), instantiated per read port: 2 without interp, 4 with.

Verification (PHASE_W=32, LUT_AW=9, OUT_W=16)
REQ-034 SHALL cover: rst, inc_load 2^23, en=1, phase_off=0 -> first valid_o at cycle 3: sin_o=201, cos_o=32766; sample 128: sin_o=32766, cos_o=-201.
REQ-035 SHALL cover: inc=2^31, en continuous -> sin_o alternates 201, -201; accumulator wraps without glitch.
REQ-036 SHALL cover: inc=2^23 stream, sync_clr pulsed with en -> that sample sin_o=201, next sample sin_o=603.
REQ-037 SHALL cover: inc_load 2^24 mid-stream -> step doubles starting with the increment after the load cycle.
REQ-038 SHALL cover: en gapped 1-0-1 -> exactly two valid_o pulses, LAT apart from their en cycles, outputs held between them.
REQ-039 SHALL cover: rst mid-stream -> outputs 0 and valid_o=0 from the next cycle; with DDS_INTERP_EN and inc=2^22, second sample sin_o=402.
